// File: rtl/addsub_pkg.sv
// Shared encodings for the serial adder/subtractor and the future ALU.
package addsub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } op_e;

  // Chunk index width; a single chunk still needs one bit.
  function automatic int unsigned idx_width(input int unsigned chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result handshake bundle of the serial adder/subtractor.
interface serial_addsub_if #(
  parameter int unsigned N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         sel;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         c;
  logic         o;
  logic         z;

  modport master (
    output in_valid, x, y, sel, out_ready,
    input  in_ready, out_valid, s, c, o, z
  );

  modport slave (
    input  in_valid, x, y, sel, out_ready,
    output in_ready, out_valid, s, c, o, z
  );
endinterface

// File: rtl/addsub_chunk.sv
// K-bit combinational adder slice with carry out and carry into its top bit.
module addsub_chunk #(
  parameter int unsigned K = 2
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [K:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{K{1'b0}}, cin};
    sum  = full[K-1:0];
    cout = full[K];
    // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out by XOR.
    cmsb = full[K-1] ^ a[K-1] ^ b[K-1];
  end

endmodule

// File: rtl/serial_addsub.sv
// Serial N-bit add/subtract, K bits per cycle, with carry, signed overflow and zero flags.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned K = 2
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);

  if (N < 2 || K == 0 || (N % K) != 0) begin : g_param_check
    $error("serial_addsub: illegal parameters N=%0d K=%0d", N, K);
  end

  localparam int unsigned Chunks = N / K;
  localparam int unsigned IdxW = idx_width(Chunks);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Chunks - 1);

  state_e          state_q;
  logic [N-1:0]    x_q;
  logic [N-1:0]    t_q;
  logic [N-1:0]    s_q;
  logic            carry_q;
  logic            c_q;
  logic            o_q;
  logic            z_q;
  logic [IdxW-1:0] idx_q;

  logic [31:0]     shamt;
  logic [N-1:0]    x_sh;
  logic [N-1:0]    t_sh;
  logic [K-1:0]    a_chunk;
  logic [K-1:0]    b_chunk;
  logic [K-1:0]    sum;
  logic            cout;
  logic            cmsb;
  logic [N-1:0]    s_d;
  logic            is_sub;

  assign is_sub = (op_e'(bus.sel) == OpSub);

  // Chunk select and write-back via shifts keep the datapath free of variable part-selects.
  always_comb begin
    shamt   = 32'(idx_q) * K;
    x_sh    = x_q >> shamt;
    t_sh    = t_q >> shamt;
    a_chunk = x_sh[K-1:0];
    b_chunk = t_sh[K-1:0];
    s_d     = (s_q & ~(N'({K{1'b1}}) << shamt)) | (N'(sum) << shamt);
  end

  addsub_chunk #(
    .K (K)
  ) u_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (sum),
    .cout (cout),
    .cmsb (cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      t_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      o_q     <= 1'b0;
      z_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            x_q     <= bus.x;
            t_q     <= bus.y ^ {N{is_sub}};
            carry_q <= is_sub;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          s_q     <= s_d;
          carry_q <= cout;
          if (idx_q == LastIdx) begin
            c_q     <= cout;
            o_q     <= cout ^ cmsb;
            z_q     <= (s_d == '0);
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.o         = o_q;
  assign bus.z         = z_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed table at K=2, handshake corner cases, random ops at K=1..8.
module tb_serial_addsub;
  localparam int unsigned N = 8;
  localparam int Main = 1;  // instance index of the K=2 DUT

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic sel;
  logic out_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;

  logic         rdy_a [4];
  logic         vld_a [4];
  logic [N-1:0] s_a   [4];
  logic         c_a   [4];
  logic         o_a   [4];
  logic         z_a   [4];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Four DUTs share stimulus; instance g processes 1<<g bits per cycle.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_addsub_if #(.N(N)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.x         = x;
    assign bus.y         = y;
    assign bus.sel       = sel;
    assign bus.out_ready = out_ready;
    assign rdy_a[g]      = bus.in_ready;
    assign vld_a[g]      = bus.out_valid;
    assign s_a[g]        = bus.s;
    assign c_a[g]        = bus.c;
    assign o_a[g]        = bus.o;
    assign z_a[g]        = bus.z;

    serial_addsub #(
      .N (N),
      .K (1 << g)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         sel;
    logic [N-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: {z, o, c, s} from a full-width add of x, y^sel and sel.
  function automatic logic [N+2:0] model(input logic [N-1:0] xa, input logic [N-1:0] ya,
                                         input logic sa);
    logic [N-1:0] t;
    logic [N:0]   r;
    logic         ov;
    t  = ya ^ {N{sa}};
    r  = {1'b0, xa} + {1'b0, t} + {{N{1'b0}}, sa};
    ov = (xa[N-1] == t[N-1]) && (r[N-1] != xa[N-1]);
    return {(r[N-1:0] == '0), ov, r[N], r[N-1:0]};
  endfunction

  // One op on the K=2 DUT with out_ready high; operands are scrambled after accept.
  task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] ya, input logic sa,
                        output logic [N-1:0] so, output logic co, output logic oo,
                        output logic zo, output int lat);
    @(negedge clk);
    chk("in_ready before accept", 32'(rdy_a[Main]), 32'd1);
    in_valid  = 1'b1;
    x         = xa;
    y         = ya;
    sel       = sa;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    x        = ~xa;
    y        = N'($urandom);
    sel      = ~sa;
    lat      = 0;
    while (!vld_a[Main] && lat < 20) begin
      lat++;
      @(negedge clk);
      x = N'($urandom);
      y = N'($urandom);
    end
    so = s_a[Main];
    co = c_a[Main];
    oo = o_a[Main];
    zo = z_a[Main];
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [N-1:0] so;
    logic         co;
    logic         oo;
    logic         zo;
    int           lat;
    logic [N+2:0] exp;
    int           lat_a [4];
    int           cyc;
    bit           all_seen;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h5A, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{8'h01, 8'h80, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{8'hC8, 8'h64, 1'b1, 8'h64, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; sel = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 32'(rdy_a[Main]), 32'd1);
    chk("reset out_valid", 32'(vld_a[Main]), 32'd0);
    chk("reset s", 32'(s_a[Main]), 32'd0);
    chk("reset c/o/z", {29'd0, c_a[Main], o_a[Main], z_a[Main]}, 32'd0);

    // Directed table, K=2: latency N/K = 4.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].sel, so, co, oo, zo, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d s", i), 32'(so), 32'(vecs[i].s));
      chk($sformatf("vec%0d c", i), 32'(co), 32'(vecs[i].c));
      chk($sformatf("vec%0d o", i), 32'(oo), 32'(vecs[i].o));
      chk($sformatf("vec%0d z", i), 32'(zo), 32'(vecs[i].z));
    end

    // Backpressure: 0x12 + 0x34 held in DONE while inputs toggle.
    @(negedge clk);
    in_valid = 1'b1; x = 8'h12; y = 8'h34; sel = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!vld_a[Main] && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("bp latency", 32'(cyc), 32'd4);
    for (int i = 0; i < 5; i++) begin
      x = N'($urandom); y = N'($urandom); in_valid = ~in_valid; sel = ~sel;
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", i), 32'(vld_a[Main]), 32'd1);
      chk($sformatf("bp%0d in_ready", i), 32'(rdy_a[Main]), 32'd0);
      chk($sformatf("bp%0d s", i), 32'(s_a[Main]), 32'h46);
      chk($sformatf("bp%0d c/o/z", i), {29'd0, c_a[Main], o_a[Main], z_a[Main]}, 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1; x = 8'h01; y = 8'h01; sel = 1'b0;
    @(negedge clk);
    chk("bp release in_ready", 32'(rdy_a[Main]), 32'd1);
    chk("bp release out_valid", 32'(vld_a[Main]), 32'd0);
    @(negedge clk);
    chk("bp next accepted", 32'(rdy_a[Main]), 32'd0);
    in_valid = 1'b0;
    cyc = 0;
    while (!vld_a[Main] && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("bp next latency", 32'(cyc), 32'd4);
    chk("bp next s", 32'(s_a[Main]), 32'h02);

    // Reset while RUN is on chunk 2 aborts the op.
    @(negedge clk);
    in_valid = 1'b1; x = 8'h0F; y = 8'h01; sel = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", 32'(rdy_a[Main]), 32'd1);
    chk("abort out_valid", 32'(vld_a[Main]), 32'd0);
    chk("abort s", 32'(s_a[Main]), 32'd0);
    run_op(8'h0F, 8'h01, 1'b0, so, co, oo, zo, lat);
    chk("post-abort latency", 32'(lat), 32'd4);
    chk("post-abort s", 32'(so), 32'h10);
    chk("post-abort c/o/z", {29'd0, co, oo, zo}, 32'd0);

    // Random ops across K = 1, 2, 4, 8 against the reference model.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int it = 0; it < 16; it++) begin
      @(negedge clk);
      in_valid = 1'b1; x = N'($urandom); y = N'($urandom); sel = 1'($urandom);
      exp = model(x, y, sel);
      @(negedge clk);
      in_valid = 1'b0; x = N'($urandom); y = N'($urandom);
      for (int g = 0; g < 4; g++) lat_a[g] = -1;
      cyc = 0;
      all_seen = 1'b0;
      while (cyc < 20 && !all_seen) begin
        all_seen = 1'b1;
        for (int g = 0; g < 4; g++) begin
          if (vld_a[g] && lat_a[g] < 0) lat_a[g] = cyc;
          if (lat_a[g] < 0) all_seen = 1'b0;
        end
        if (!all_seen) begin
          cyc++;
          @(negedge clk);
        end
      end
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("rnd%0d K%0d latency", it, 1 << g), 32'(lat_a[g]), 32'(8 >> g));
        chk($sformatf("rnd%0d K%0d s", it, 1 << g), 32'(s_a[g]), 32'(exp[N-1:0]));
        chk($sformatf("rnd%0d K%0d c", it, 1 << g), 32'(c_a[g]), 32'(exp[N]));
        chk($sformatf("rnd%0d K%0d o", it, 1 << g), 32'(o_a[g]), 32'(exp[N+1]));
        chk($sformatf("rnd%0d K%0d z", it, 1 << g), 32'(z_a[g]), 32'(exp[N+2]));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The parameter N SHALL default to 8 and give the operand and result width; N >= 2.
REQ-002 The parameter K SHALL default to 2 and give the bits processed per cycle; K >= 1 and N % K == 0; an illegal combination SHALL fail elaboration.
REQ-003 The port clk SHALL be an input, 1 bit wide: the single clock, rising-edge.
REQ-004 The port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 The port in_valid SHALL be an input, 1 bit wide: an operation request is present.
REQ-006 The port in_ready SHALL be an output, 1 bit wide: the block can accept a request.
REQ-007 The ports x and y SHALL be inputs, N bits wide: the operands.
REQ-008 The port sel SHALL be an input, 1 bit wide: 0 selects add, 1 selects subtract (x - y).
REQ-009 The port out_valid SHALL be an output, 1 bit wide: the result and flags are valid.
REQ-010 The port out_ready SHALL be an input, 1 bit wide: the consumer accepts the result.
REQ-011 The port s SHALL be an output, N bits wide: the result.
REQ-012 The ports c, o and z SHALL be outputs, 1 bit wide each: carry out, signed overflow and zero.

Function
REQ-013 The block SHALL be a 3-state FSM: IDLE, RUN, DONE.
REQ-014 in_ready SHALL equal (state == IDLE); no other state accepts a request.
REQ-015 A handshake (in_valid && in_ready) SHALL register four values:
- x;
- t = y ^ {N{sel}};
- carry = sel;
- chunk index = 0.
It SHALL then move the FSM to RUN.
REQ-016 Each RUN cycle SHALL add chunk i of x, chunk i of t and the carry, LSB chunk first; it SHALL write the K-bit sum into s[i*K +: K] and register the chunk carry-out as the new carry.
REQ-017 After the last chunk (i == N/K-1) the FSM SHALL enter DONE; out_valid SHALL equal (state == DONE).
REQ-018 Latency SHALL be exactly N/K cycles from the accept edge to out_valid high; when K == N, out_valid SHALL be high on the cycle after accept.
REQ-019 In DONE, a cycle with out_ready high SHALL return the FSM to IDLE; with out_ready low, s, c, o and z SHALL hold unchanged indefinitely.
REQ-020 Back-to-back operation SHALL insert exactly one cycle with in_ready high between the result handshake and the next accept (no bypass).
REQ-021 c SHALL be the carry out of bit N-1 of x + t + sel; for subtract, c = 1 means no borrow.
REQ-022 o SHALL be the carry into bit N-1 XOR the carry out of bit N-1, registered on the final chunk.
REQ-023 z SHALL be 1 iff s == 0, valid whenever out_valid is high.
REQ-024 in_valid, x, y and sel SHALL be ignored outside IDLE; operands SHALL be captured only on accept, and later input changes SHALL not affect the result.
REQ-025 s, c, o and z MAY change during RUN; consumers SHALL sample them only while out_valid is high.

Reset
REQ-026 While rst is high at a clock edge, the block SHALL enter IDLE.
REQ-027 Reset SHALL clear s, c, o, z, the carry and the chunk index to 0, giving in_ready = 1 and out_valid = 0 after reset.
REQ-028 Reset during RUN or DONE SHALL abort the operation without emitting a result; rst SHALL take priority over any simultaneous handshake.

Structure
REQ-029 The FSM state encoding and the add/sub sel encoding SHALL reside in a shared package addsub_pkg, for reuse by the future ALU.
REQ-030 The per-chunk arithmetic SHALL be one combinational sub-module, addsub_chunk.
REQ-031 addsub_chunk SHALL be parameterised by K and SHALL provide:
- inputs: a, b, cin;
- outputs: sum, cout, and cmsb (the carry into its top bit, used for o).
REQ-032 The chunk index width SHALL be max(1, clog2(N/K)).

Verification (N=8, K=2 unless noted)
REQ-033 Add test: x=0x0F, y=0x01, sel=0 -> after 4 cycles s=0x10, c=0, o=0, z=0.
REQ-034 Overflow and zero tests:
- x=0x80, y=0x01, sel=1 -> s=0x7F, c=1, o=1, z=0;
- x=0x5A, y=0x5A, sel=1 -> s=0x00, c=1, o=0, z=1.
REQ-035 Borrow and add-overflow tests:
- x=0x00, y=0x01, sel=1 -> s=0xFF, c=0, o=0;
- x=0x7F, y=0x01, sel=0 -> s=0x80, o=1.
REQ-036 Backpressure test: hold out_ready=0 for 5 cycles in DONE and toggle x, y and in_valid -> outputs stable, in_ready=0; then out_ready=1 -> IDLE, next accept one cycle later.
REQ-037 Reset test: assert rst at RUN chunk 2 -> next cycle in_ready=1, out_valid=0, s=0; a fresh op then completes correctly.
REQ-038 Random tests: compare against a reference model across random operands at K=1, 2, 4, 8.
